// File: rtl/fft_seq_pkg.sv
// ---------------------------------------------------------------------------
// fft_seq_pkg
//   Shared types and helpers for the radix-2 DIF FFT stage sequencer.
//   - seq_state_t : sequencer FSM states
//   - DRAIN_W     : width of the inter-stage drain counter
//   - bitrev()    : reverse the low 'width' bits of a value (up to 16 bits)
// ---------------------------------------------------------------------------
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_READOUT,
        ST_DONE
    } seq_state_t;

    localparam int unsigned DRAIN_W = 4;

    function automatic logic [15:0] bitrev(input logic [15:0] value,
                                           input int unsigned width);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < width && i < 16; i++) begin
            r[i] = value[width - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_addr.sv
// ---------------------------------------------------------------------------
// fft_twiddle_addr
//   Combinational twiddle ROM address for a radix-2 DIF butterfly.
//   coeff_addr = (idx & (N>>(stage+1) - 1)) << stage, truncated to AW bits.
// Parameters: N (FFT length), AW (index/address width)
// Ports:
//   stage      in  4   stage number s
//   idx        in  AW  butterfly index j
//   coeff_addr out AW  twiddle ROM address
// ---------------------------------------------------------------------------
module fft_twiddle_addr #(
    parameter int N  = 128,
    parameter int AW = $clog2(N) - 1
) (
    input  logic [3:0]    stage,
    input  logic [AW-1:0] idx,
    output logic [AW-1:0] coeff_addr
);

    logic [31:0] half;
    logic [31:0] mask;

    always_comb begin
        half       = 32'(N) >> (32'(stage) + 32'd1);
        mask       = (half == '0) ? '0 : (half - 32'd1);
        coeff_addr = AW'((32'(idx) & mask) << stage);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
//   Frame/stage scheduler for the radix-2 DIF FFT datapath. A start pulse in
//   IDLE walks all NSTAGES stages, issuing one butterfly slot per accepted
//   transfer, inserting a drain gap after each stage and pulsing done at the
//   end of the frame. All outputs are registered.
// Configuration macro: FFT_SEQ_BITREV_EN -- when defined, N bit-reversed read
//   addresses are issued after the last drain, before done. Otherwise rd_valid
//   and rd_addr are constant 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       frame start pulse (accepted only in IDLE)
//   busy        frame in progress
//   done        one-cycle frame-completion pulse
//   bf_valid    butterfly slot present; bf_ready accepts it
//   bf_stage    stage s
//   bf_idx      butterfly index j
//   coeff_addr  twiddle ROM address for (s, j)
//   bf_last     slot is j = N/2-1
//   rd_valid    bit-reversed readout address valid
//   rd_addr     bit-reversed readout address
// ---------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_seq_pkg::*;
#(
    parameter int N        = 128,
    parameter int NSTAGES  = $clog2(N),
    parameter int AW       = $clog2(N) - 1,
    parameter int PIPE_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          bf_valid,
    input  logic          bf_ready,
    output logic [3:0]    bf_stage,
    output logic [AW-1:0] bf_idx,
    output logic [AW-1:0] coeff_addr,
    output logic          bf_last,
    output logic          rd_valid,
    output logic [AW:0]   rd_addr
);

    localparam int RW = AW + 1;
    localparam logic [AW-1:0] LAST_J = AW'(N / 2 - 1);
    localparam logic [3:0]    LAST_S = 4'(NSTAGES - 1);

    seq_state_t         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [AW-1:0]      idx_inc;
    logic [AW-1:0]      coeff_next;

    // The twiddle address is registered together with the index, so it is
    // evaluated for the index about to be issued. A stage's first slot has
    // j=0 and therefore always address 0, so only j+1 needs evaluating.
    assign idx_inc = bf_idx + AW'(1);

    fft_twiddle_addr #(
        .N  (N),
        .AW (AW)
    ) u_twiddle (
        .stage      (bf_stage),
        .idx        (idx_inc),
        .coeff_addr (coeff_next)
    );

`ifdef FFT_SEQ_BITREV_EN
    localparam logic [RW-1:0] RD_LAST = RW'(N - 1);
    logic [RW-1:0] rd_cnt;
`else
    assign rd_valid = 1'b0;
    assign rd_addr  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bf_valid   <= 1'b0;
            bf_stage   <= '0;
            bf_idx     <= '0;
            coeff_addr <= '0;
            bf_last    <= 1'b0;
            drain_cnt  <= '0;
`ifdef FFT_SEQ_BITREV_EN
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            rd_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        bf_valid   <= 1'b1;
                        bf_stage   <= '0;
                        bf_idx     <= '0;
                        coeff_addr <= '0;
                        bf_last    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bf_ready) begin
                        if (bf_idx == LAST_J) begin
                            state     <= ST_DRAIN;
                            bf_valid  <= 1'b0;
                            bf_last   <= 1'b0;
                            drain_cnt <= DRAIN_W'(PIPE_LAT);
                        end else begin
                            bf_idx     <= idx_inc;
                            coeff_addr <= coeff_next;
                            bf_last    <= (idx_inc == LAST_J);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leaving on a count of 1 (or 0 when PIPE_LAT=0) makes the
                    // registered gap exactly max(PIPE_LAT,1) cycles long.
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        if (bf_stage != LAST_S) begin
                            state      <= ST_RUN;
                            bf_valid   <= 1'b1;
                            bf_stage   <= bf_stage + 4'd1;
                            bf_idx     <= '0;
                            coeff_addr <= '0;
                        end else begin
`ifdef FFT_SEQ_BITREV_EN
                            state    <= ST_READOUT;
                            rd_valid <= 1'b1;
                            rd_addr  <= '0;
                            rd_cnt   <= '0;
`else
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
`ifdef FFT_SEQ_BITREV_EN
                ST_READOUT: begin
                    if (rd_cnt == RD_LAST) begin
                        state    <= ST_DONE;
                        rd_valid <= 1'b0;
                        rd_addr  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        rd_cnt  <= rd_cnt + RW'(1);
                        rd_addr <= RW'(bitrev(16'(rd_cnt + RW'(1)), RW));
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
//   Directed self-checking bench for fft_stage_sequencer. Two instances:
//   dut8 (N=8, PIPE_LAT=0) and dut128 (N=128, PIPE_LAT=4).
//   Honours FFT_SEQ_BITREV_EN if it is defined for the build.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;

`ifdef FFT_SEQ_BITREV_EN
    localparam int DONE8   = 24;
    localparam int DONE128 = 605;
    int exp_rd8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    localparam int DONE8   = 16;
    localparam int DONE128 = 477;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, ready8 = 1'b1;
    logic       busy8, done8, valid8, last8, rdv8;
    logic [3:0] stage8;
    logic [1:0] idx8, coeff8;
    logic [2:0] rda8;

    logic       start128 = 1'b0, ready128 = 1'b1;
    logic       busy128, done128, valid128, last128, rdv128;
    logic [3:0] stage128;
    logic [5:0] idx128, coeff128;
    logic [6:0] rda128;

    int checks   = 0;
    int failures = 0;

    int exp_coeff8 [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    always #5 clk = ~clk;

    fft_stage_sequencer #(.N(8), .PIPE_LAT(0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .bf_valid(valid8), .bf_ready(ready8), .bf_stage(stage8),
        .bf_idx(idx8), .coeff_addr(coeff8), .bf_last(last8),
        .rd_valid(rdv8), .rd_addr(rda8)
    );

    fft_stage_sequencer #(.N(128), .PIPE_LAT(4)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .busy(busy128), .done(done128),
        .bf_valid(valid128), .bf_ready(ready128), .bf_stage(stage128),
        .bf_idx(idx128), .coeff_addr(coeff128), .bf_last(last128),
        .rd_valid(rdv128), .rd_addr(rda128)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full N=8 frame with ready held high; optionally pulses start mid-frame
    // and during the done cycle, both of which must be ignored.
    task automatic run_frame8(input bit inject);
        int slot;
        start8 = 1'b1;
        ready8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 1; k <= DONE8; k++) begin
            start8 = inject && (k == 3 || k == DONE8);
            if (k < DONE8) begin
                chk("f8_busy", 32'(busy8), 32'd1);
                chk("f8_done_low", 32'(done8), 32'd0);
                if (k <= 15) begin
                    chk("f8_rdv_low", 32'(rdv8), 32'd0);
                    if (k % 5 == 0) begin
                        chk("f8_gap_valid", 32'(valid8), 32'd0);
                        chk("f8_gap_last", 32'(last8), 32'd0);
                    end else begin
                        slot = k - 1 - k / 5;
                        chk("f8_valid", 32'(valid8), 32'd1);
                        chk("f8_stage", 32'(stage8), 32'(slot / 4));
                        chk("f8_idx", 32'(idx8), 32'(slot % 4));
                        chk("f8_coeff", 32'(coeff8), 32'(exp_coeff8[slot]));
                        chk("f8_last", 32'(last8), 32'(slot % 4 == 3));
                    end
                end else begin
`ifdef FFT_SEQ_BITREV_EN
                    chk("f8_rd_valid", 32'(rdv8), 32'd1);
                    chk("f8_rd_addr", 32'(rda8), 32'(exp_rd8[k - 16]));
                    chk("f8_rd_bfvalid", 32'(valid8), 32'd0);
`endif
                end
            end else begin
                chk("f8_done", 32'(done8), 32'd1);
                chk("f8_done_busy", 32'(busy8), 32'd0);
                chk("f8_done_valid", 32'(valid8), 32'd0);
                chk("f8_done_rdv", 32'(rdv8), 32'd0);
            end
            tick();
        end
        start8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("f8_idle_busy", 32'(busy8), 32'd0);
            chk("f8_idle_done", 32'(done8), 32'd0);
            chk("f8_idle_valid", 32'(valid8), 32'd0);
            tick();
        end
    endtask

    initial begin
        int slot;
        int ev;
        int cyc;
        int found;
        int p;
        int s;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_valid", 32'(valid8), 32'd0);
        chk("rst_stage", 32'(stage8), 32'd0);
        chk("rst_idx", 32'(idx8), 32'd0);
        chk("rst_coeff", 32'(coeff8), 32'd0);
        chk("rst_last", 32'(last8), 32'd0);
        chk("rst_rdv", 32'(rdv8), 32'd0);
        chk("rst_rda", 32'(rda8), 32'd0);
        chk("rst_busy128", 32'(busy128), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- N=8, ready high
        run_frame8(1'b0);

        // ---------------- N=8, ready toggling 1,0,1,0
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        slot = 0;
        ev   = 1;
        cyc  = 0;
        while (slot < 12 && cyc < 60) begin
            chk("tg_valid", 32'(valid8), 32'(ev));
            if (ev != 0) begin
                chk("tg_stage", 32'(stage8), 32'(slot / 4));
                chk("tg_idx", 32'(idx8), 32'(slot % 4));
                chk("tg_coeff", 32'(coeff8), 32'(exp_coeff8[slot]));
                chk("tg_last", 32'(last8), 32'(slot % 4 == 3));
                if (cyc % 2 == 0) begin
                    ready8 = 1'b1;
                    slot++;
                    if (slot % 4 == 0) ev = 0;
                end else begin
                    ready8 = 1'b0;
                end
            end else begin
                ready8 = (cyc % 2 == 0);
                ev = 1;
            end
            cyc++;
            tick();
        end
        chk("tg_all_slots", 32'(slot), 32'd12);
        ready8 = 1'b1;
        chk("tg_final_gap", 32'(valid8), 32'd0);
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            tick();
            if (done8 === 1'b1) found = k;
        end
        chk("tg_done_delay", 32'(found), 32'(DONE8 - 15));

        // ---------------- reset in stage 1, j=2
        tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 2; k <= 8; k++) tick();
        chk("ra_pre_stage", 32'(stage8), 32'd1);
        chk("ra_pre_idx", 32'(idx8), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ra_busy", 32'(busy8), 32'd0);
        chk("ra_done", 32'(done8), 32'd0);
        chk("ra_valid", 32'(valid8), 32'd0);
        chk("ra_stage", 32'(stage8), 32'd0);
        chk("ra_idx", 32'(idx8), 32'd0);
        chk("ra_coeff", 32'(coeff8), 32'd0);
        chk("ra_last", 32'(last8), 32'd0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) found = 1;
        end
        chk("ra_no_done", 32'(found), 32'd0);
        run_frame8(1'b0);

        // ---------------- start while busy and in the done cycle
        run_frame8(1'b1);

        // ---------------- N=128, PIPE_LAT=4
        start128 = 1'b1;
        tick();
        start128 = 1'b0;
        for (int k = 1; k < DONE128; k++) begin
            s = (k - 1) / 68;
            p = (k - 1) % 68;
            if (s >= 7) begin
`ifdef FFT_SEQ_BITREV_EN
                chk("n128_rdv", 32'(rdv128), 32'd1);
`endif
                chk("n128_rd_bfvalid", 32'(valid128), 32'd0);
            end else if (p < 64) begin
                chk("n128_valid", 32'(valid128), 32'd1);
                chk("n128_stage", 32'(stage128), 32'(s));
                chk("n128_idx", 32'(idx128), 32'(p));
                if (s == 0) chk("n128_coeff_s0", 32'(coeff128), 32'(p));
                if (s == 6) chk("n128_coeff_s6", 32'(coeff128), 32'd0);
                chk("n128_last", 32'(last128), 32'(p == 63));
            end else begin
                chk("n128_gap", 32'(valid128), 32'd0);
            end
            chk("n128_done_low", 32'(done128), 32'd0);
            tick();
        end
        chk("n128_done", 32'(done128), 32'd1);
        chk("n128_done_busy", 32'(busy128), 32'd0);
        tick();
        chk("n128_done_pulse", 32'(done128), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
